bp_cfg_reg_endpoint: RTL and testbench



---
 rtl/bp_cfg_reg_endpoint.sv | 196 +++++++++++++++++++
 tb/tb_bp_cfg_reg_endpoint.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_reg_endpoint.sv
// Tile configuration endpoint: decodes single-beat cfg commands, holds the tile
// config registers, forwards IRF/CSR/ucode window writes and returns one response per command.
module bp_cfg_reg_endpoint
  #(parameter int unsigned core_id_width_p   = 4
  , parameter int unsigned lce_id_width_p    = 4
  , parameter int unsigned vaddr_width_p     = 39
  , parameter int unsigned cce_instr_width_p = 48
  , parameter logic [63:0] boot_pc_p         = 64'h8000_0000
  )
  (input  logic                          clk_i
  , input  logic                         reset_n_i

  , input  logic                         cfg_v_i
  , input  logic                         cfg_w_i
  , input  logic [15:0]                  cfg_addr_i
  , input  logic [63:0]                  cfg_data_i
  , output logic                         cfg_ready_o

  , output logic                         resp_v_o
  , output logic [63:0]                  resp_data_o
  , output logic                         resp_err_o
  , input  logic                         resp_yumi_i

  , output logic                         reset_o
  , output logic                         freeze_o
  , output logic [core_id_width_p-1:0]   core_id_o
  , output logic [core_id_width_p-1:0]   cce_id_o
  , output logic [1:0]                   icache_mode_o
  , output logic [1:0]                   dcache_mode_o
  , output logic [vaddr_width_p-1:0]     npc_o
  , output logic [1:0]                   priv_o
  , output logic                         cce_mode_o
  , output logic [lce_id_width_p-1:0]    num_lce_o

  , output logic                         irf_w_v_o
  , output logic [4:0]                   irf_addr_o
  , output logic [63:0]                  irf_data_o

  , output logic                         csr_w_v_o
  , output logic [11:0]                  csr_addr_o
  , output logic [63:0]                  csr_data_o

  , output logic                         ucode_w_v_o
  , output logic [11:0]                  ucode_addr_o
  , output logic [cce_instr_width_p-1:0] ucode_data_o
  );

  localparam int unsigned data_width_lp     = 64;
  localparam int unsigned irf_addr_width_lp = 5;
  localparam logic [15:0] irf_base_lp       = 16'h0050;
  localparam logic [15:0] irf_last_lp       = 16'h006F;

  typedef enum logic [0:0] {e_ready, e_resp} state_e;

  typedef enum logic [3:0] {
    e_sel_none, e_sel_reset, e_sel_freeze, e_sel_core_id, e_sel_icache,
    e_sel_npc, e_sel_dcache, e_sel_priv, e_sel_cce_id, e_sel_cce_mode,
    e_sel_num_lce, e_sel_irf, e_sel_csr, e_sel_ucode
  } sel_e;

  state_e                   state_q;
  sel_e                     sel_c;
  logic [data_width_lp-1:0] rd_data_c;
  logic                     accept_c;

  assign accept_c = cfg_v_i & (state_q == e_ready);

  // Offset decode: exact register offsets first, then the forwarded windows
  always_comb begin
    sel_c = e_sel_none;
    case (cfg_addr_i)
      16'h0001: sel_c = e_sel_reset;
      16'h0002: sel_c = e_sel_freeze;
      16'h0003: sel_c = e_sel_core_id;
      16'h0022: sel_c = e_sel_icache;
      16'h0040: sel_c = e_sel_npc;
      16'h0042: sel_c = e_sel_dcache;
      16'h0043: sel_c = e_sel_priv;
      16'h0080: sel_c = e_sel_cce_id;
      16'h0081: sel_c = e_sel_cce_mode;
      16'h0082: sel_c = e_sel_num_lce;
      default: begin
        if (cfg_addr_i >= irf_base_lp && cfg_addr_i <= irf_last_lp)
          sel_c = e_sel_irf;
        else if (cfg_addr_i[15:12] == 4'h6)
          sel_c = e_sel_csr;
        else if (cfg_addr_i[15:12] == 4'h8)
          sel_c = e_sel_ucode;
      end
    endcase
  end

  // Read mux; windows and unmapped offsets read as zero
  always_comb begin
    rd_data_c = '0;
    case (sel_c)
      e_sel_reset:    rd_data_c = data_width_lp'(reset_o);
      e_sel_freeze:   rd_data_c = data_width_lp'(freeze_o);
      e_sel_core_id:  rd_data_c = data_width_lp'(core_id_o);
      e_sel_icache:   rd_data_c = data_width_lp'(icache_mode_o);
      e_sel_npc:      rd_data_c = data_width_lp'(npc_o);
      e_sel_dcache:   rd_data_c = data_width_lp'(dcache_mode_o);
      e_sel_priv:     rd_data_c = data_width_lp'(priv_o);
      e_sel_cce_id:   rd_data_c = data_width_lp'(cce_id_o);
      e_sel_cce_mode: rd_data_c = data_width_lp'(cce_mode_o);
      e_sel_num_lce:  rd_data_c = data_width_lp'(num_lce_o);
      default:        rd_data_c = '0;
    endcase
  end

  // Handshake FSM, config registers, response buffer and window pulses
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_ready;
      cfg_ready_o   <= 1'b1;
      resp_v_o      <= 1'b0;
      resp_data_o   <= '0;
      resp_err_o    <= 1'b0;
      reset_o       <= 1'b1;
      freeze_o      <= 1'b1;
      core_id_o     <= '0;
      cce_id_o      <= '0;
      icache_mode_o <= '0;
      dcache_mode_o <= '0;
      npc_o         <= boot_pc_p[vaddr_width_p-1:0];
      priv_o        <= '0;
      cce_mode_o    <= 1'b0;
      num_lce_o     <= '0;
      irf_w_v_o     <= 1'b0;
      irf_addr_o    <= '0;
      irf_data_o    <= '0;
      csr_w_v_o     <= 1'b0;
      csr_addr_o    <= '0;
      csr_data_o    <= '0;
      ucode_w_v_o   <= 1'b0;
      ucode_addr_o  <= '0;
      ucode_data_o  <= '0;
    end else begin
      irf_w_v_o   <= 1'b0;
      csr_w_v_o   <= 1'b0;
      ucode_w_v_o <= 1'b0;
      case (state_q)
        e_ready: begin
          if (accept_c) begin
            state_q     <= e_resp;
            cfg_ready_o <= 1'b0;
            resp_v_o    <= 1'b1;
            resp_data_o <= cfg_w_i ? '0 : rd_data_c;
            resp_err_o  <= (sel_c == e_sel_none);
            if (cfg_w_i) begin
              case (sel_c)
                e_sel_reset:    reset_o       <= cfg_data_i[0];
                e_sel_freeze:   freeze_o      <= cfg_data_i[0];
                e_sel_core_id:  core_id_o     <= cfg_data_i[core_id_width_p-1:0];
                e_sel_icache:   icache_mode_o <= cfg_data_i[1:0];
                e_sel_npc:      npc_o         <= cfg_data_i[vaddr_width_p-1:0];
                e_sel_dcache:   dcache_mode_o <= cfg_data_i[1:0];
                e_sel_priv:     priv_o        <= cfg_data_i[1:0];
                e_sel_cce_id:   cce_id_o      <= cfg_data_i[core_id_width_p-1:0];
                e_sel_cce_mode: cce_mode_o    <= cfg_data_i[0];
                e_sel_num_lce:  num_lce_o     <= cfg_data_i[lce_id_width_p-1:0];
                e_sel_irf: begin
                  irf_w_v_o  <= 1'b1;
                  irf_addr_o <= irf_addr_width_lp'(cfg_addr_i - irf_base_lp);
                  irf_data_o <= cfg_data_i;
                end
                e_sel_csr: begin
                  csr_w_v_o  <= 1'b1;
                  csr_addr_o <= cfg_addr_i[11:0];
                  csr_data_o <= cfg_data_i;
                end
                e_sel_ucode: begin
                  ucode_w_v_o  <= 1'b1;
                  ucode_addr_o <= cfg_addr_i[11:0];
                  ucode_data_o <= cfg_data_i[cce_instr_width_p-1:0];
                end
                default: ;
              endcase
            end
          end
        end
        e_resp: begin
          if (resp_yumi_i) begin
            state_q     <= e_ready;
            cfg_ready_o <= 1'b1;
            resp_v_o    <= 1'b0;
            resp_data_o <= '0;
            resp_err_o  <= 1'b0;
          end
        end
        default: state_q <= e_ready;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_reg_endpoint.sv
// Self-checking bench for bp_cfg_reg_endpoint: directed literal checks plus
// randomized traffic compared every cycle against a table-driven register-map model.
module tb_bp_cfg_reg_endpoint;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cfg_v_i, cfg_w_i;
  logic [15:0] cfg_addr_i;
  logic [63:0] cfg_data_i;
  logic        cfg_ready_o;
  logic        resp_v_o;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        resp_yumi_i;
  logic        reset_o, freeze_o;
  logic [3:0]  core_id_o, cce_id_o;
  logic [1:0]  icache_mode_o, dcache_mode_o;
  logic [38:0] npc_o;
  logic [1:0]  priv_o;
  logic        cce_mode_o;
  logic [3:0]  num_lce_o;
  logic        irf_w_v_o;
  logic [4:0]  irf_addr_o;
  logic [63:0] irf_data_o;
  logic        csr_w_v_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_data_o;
  logic        ucode_w_v_o;
  logic [11:0] ucode_addr_o;
  logic [47:0] ucode_data_o;

  bp_cfg_reg_endpoint dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .resp_yumi_i(resp_yumi_i),
    .reset_o(reset_o), .freeze_o(freeze_o), .core_id_o(core_id_o), .cce_id_o(cce_id_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o), .npc_o(npc_o),
    .priv_o(priv_o), .cce_mode_o(cce_mode_o), .num_lce_o(num_lce_o),
    .irf_w_v_o(irf_w_v_o), .irf_addr_o(irf_addr_o), .irf_data_o(irf_data_o),
    .csr_w_v_o(csr_w_v_o), .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
    .ucode_w_v_o(ucode_w_v_o), .ucode_addr_o(ucode_addr_o), .ucode_data_o(ucode_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Register map as a table: index, width and reset value per mapped offset
  function automatic int reg_idx(input logic [15:0] a);
    case (a)
      16'h0001: return 0;  16'h0002: return 1;  16'h0003: return 2;
      16'h0022: return 3;  16'h0040: return 4;  16'h0042: return 5;
      16'h0043: return 6;  16'h0080: return 7;  16'h0081: return 8;
      16'h0082: return 9;  default:  return -1;
    endcase
  endfunction

  function automatic int reg_width(input int i);
    case (i)
      0, 1, 8:  return 1;
      2, 7, 9:  return 4;
      4:        return 39;
      default:  return 2;
    endcase
  endfunction

  function automatic logic [63:0] reg_reset(input int i);
    case (i)
      0, 1:    return 64'd1;
      4:       return 64'h8000_0000;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [15:0] reg_off(input int i);
    case (i)
      0: return 16'h0001; 1: return 16'h0002; 2: return 16'h0003; 3: return 16'h0022;
      4: return 16'h0040; 5: return 16'h0042; 6: return 16'h0043; 7: return 16'h0080;
      8: return 16'h0081; default: return 16'h0082;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Behavioural model state
  logic [63:0] m_val [10];
  logic        m_ready, m_resp_v, m_err;
  logic [63:0] m_data;
  logic        m_irf_v, m_csr_v, m_uc_v;
  logic [4:0]  m_irf_a;
  logic [11:0] m_csr_a, m_uc_a;
  logic [63:0] m_irf_d, m_csr_d;
  logic [47:0] m_uc_d;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 10; i++) m_val[i] <= reg_reset(i);
      m_ready <= 1'b1; m_resp_v <= 1'b0; m_err <= 1'b0; m_data <= '0;
      m_irf_v <= 1'b0; m_csr_v <= 1'b0; m_uc_v <= 1'b0;
      m_irf_a <= '0; m_csr_a <= '0; m_uc_a <= '0;
      m_irf_d <= '0; m_csr_d <= '0; m_uc_d <= '0;
    end else begin
      m_irf_v <= 1'b0; m_csr_v <= 1'b0; m_uc_v <= 1'b0;
      if (m_ready && cfg_v_i) begin
        m_ready <= 1'b0; m_resp_v <= 1'b1; m_data <= '0; m_err <= 1'b0;
        if (reg_idx(cfg_addr_i) >= 0) begin
          if (cfg_w_i)
            m_val[reg_idx(cfg_addr_i)] <= cfg_data_i & mask(reg_width(reg_idx(cfg_addr_i)));
          else
            m_data <= m_val[reg_idx(cfg_addr_i)];
        end else if (cfg_addr_i >= 16'h0050 && cfg_addr_i <= 16'h006F) begin
          if (cfg_w_i) begin
            m_irf_v <= 1'b1; m_irf_a <= 5'(cfg_addr_i - 16'h0050); m_irf_d <= cfg_data_i;
          end
        end else if (cfg_addr_i >= 16'h6000 && cfg_addr_i <= 16'h6FFF) begin
          if (cfg_w_i) begin
            m_csr_v <= 1'b1; m_csr_a <= 12'(cfg_addr_i - 16'h6000); m_csr_d <= cfg_data_i;
          end
        end else if (cfg_addr_i >= 16'h8000 && cfg_addr_i <= 16'h8FFF) begin
          if (cfg_w_i) begin
            m_uc_v <= 1'b1; m_uc_a <= 12'(cfg_addr_i - 16'h8000); m_uc_d <= 48'(cfg_data_i);
          end
        end else begin
          m_err <= 1'b1;
        end
      end else if (!m_ready && resp_yumi_i) begin
        m_ready <= 1'b1; m_resp_v <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("ready", 64'(cfg_ready_o), 64'(m_ready));
      chk("resp_v", 64'(resp_v_o), 64'(m_resp_v));
      if (m_resp_v) begin
        chk("resp_data", resp_data_o, m_data);
        chk("resp_err", 64'(resp_err_o), 64'(m_err));
      end
      chk("reset_o", 64'(reset_o), m_val[0]);
      chk("freeze_o", 64'(freeze_o), m_val[1]);
      chk("core_id", 64'(core_id_o), m_val[2]);
      chk("icache_mode", 64'(icache_mode_o), m_val[3]);
      chk("npc", 64'(npc_o), m_val[4]);
      chk("dcache_mode", 64'(dcache_mode_o), m_val[5]);
      chk("priv", 64'(priv_o), m_val[6]);
      chk("cce_id", 64'(cce_id_o), m_val[7]);
      chk("cce_mode", 64'(cce_mode_o), m_val[8]);
      chk("num_lce", 64'(num_lce_o), m_val[9]);
      chk("irf_w_v", 64'(irf_w_v_o), 64'(m_irf_v));
      chk("csr_w_v", 64'(csr_w_v_o), 64'(m_csr_v));
      chk("ucode_w_v", 64'(ucode_w_v_o), 64'(m_uc_v));
      if (m_irf_v) begin
        chk("irf_addr", 64'(irf_addr_o), 64'(m_irf_a));
        chk("irf_data", irf_data_o, m_irf_d);
      end
      if (m_csr_v) begin
        chk("csr_addr", 64'(csr_addr_o), 64'(m_csr_a));
        chk("csr_data", csr_data_o, m_csr_d);
      end
      if (m_uc_v) begin
        chk("ucode_addr", 64'(ucode_addr_o), 64'(m_uc_a));
        chk("ucode_data", 64'(ucode_data_o), 64'(m_uc_d));
      end
    end
  end

  // Issue one command from a negedge in READY; returns at the negedge of the response cycle
  task automatic cmd(input logic w, input logic [15:0] a, input logic [63:0] d);
    chk("cmd_ready", 64'(cfg_ready_o), 64'd1);
    cfg_v_i = 1'b1; cfg_w_i = w; cfg_addr_i = a; cfg_data_i = d;
    @(negedge clk_i);
    cfg_v_i = 1'b0;
  endtask

  task automatic ack();
    resp_yumi_i = 1'b1;
    @(negedge clk_i);
    resp_yumi_i = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] edges [6];
    edges[0] = 16'h004F; edges[1] = 16'h0070; edges[2] = 16'h5FFF;
    edges[3] = 16'h7000; edges[4] = 16'h9000; edges[5] = 16'h0000;
    case ($urandom_range(5, 0))
      0:       return reg_off(int'($urandom_range(9, 0)));
      1:       return 16'h0050 + 16'($urandom_range(31, 0));
      2:       return 16'h6000 | 16'($urandom_range(16'h0FFF, 0));
      3:       return 16'h8000 | 16'($urandom_range(16'h0FFF, 0));
      4:       return 16'($urandom);
      default: return edges[$urandom_range(5, 0)];
    endcase
  endfunction

  initial begin
    reset_n_i = 1'b0;
    cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0; resp_yumi_i = 1'b0;
    repeat (2) @(posedge clk_i);
    chk_en = 1'b1;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_release", 64'(cfg_ready_o), 64'd1);

    // Reset values via reads
    cmd(1'b0, 16'h0001, '0); chk("rd_reset", resp_data_o, 64'd1); chk("rd_reset_err", 64'(resp_err_o), 64'd0); ack();
    cmd(1'b0, 16'h0002, '0); chk("rd_freeze", resp_data_o, 64'd1); ack();
    cmd(1'b0, 16'h0040, '0); chk("rd_npc", resp_data_o, 64'h8000_0000); chk("rd_npc_err", 64'(resp_err_o), 64'd0); ack();

    // Register write truncation and readback
    cmd(1'b1, 16'h0003, 64'hFF); chk("wr_core_id", 64'(core_id_o), 64'hF); chk("wr_resp_data", resp_data_o, 64'd0); ack();
    cmd(1'b0, 16'h0003, '0); chk("rd_core_id", resp_data_o, 64'hF); ack();
    cmd(1'b1, 16'h0001, 64'd0); chk("wr_reset", 64'(reset_o), 64'd0); ack();

    // Window pulses
    cmd(1'b1, 16'h0055, 64'hDEAD);
    chk("irf_pulse", 64'(irf_w_v_o), 64'd1); chk("irf_addr_lit", 64'(irf_addr_o), 64'd5);
    chk("irf_data_lit", irf_data_o, 64'hDEAD);
    ack(); chk("irf_pulse_end", 64'(irf_w_v_o), 64'd0);
    cmd(1'b1, 16'h6300, 64'h77); chk("csr_pulse", 64'(csr_w_v_o), 64'd1); chk("csr_addr_lit", 64'(csr_addr_o), 64'h300); ack();
    cmd(1'b1, 16'h8010, 64'h1234_5678_9ABC_DEF0);
    chk("uc_addr_lit", 64'(ucode_addr_o), 64'h010); chk("uc_data_lit", 64'(ucode_data_o), 64'h5678_9ABC_DEF0); ack();

    // Unmapped accesses
    cmd(1'b0, 16'h0004, '0); chk("unmap_rd_err", 64'(resp_err_o), 64'd1); chk("unmap_rd_data", resp_data_o, 64'd0); ack();
    cmd(1'b1, 16'h7000, 64'h5);
    chk("unmap_wr_err", 64'(resp_err_o), 64'd1); chk("unmap_wr_data", resp_data_o, 64'd0);
    chk("unmap_no_pulse", 64'({irf_w_v_o, csr_w_v_o, ucode_w_v_o}), 64'd0); chk("unmap_core_id", 64'(core_id_o), 64'hF);
    ack();

    // Back-pressure: held response, blocked command, accept right after yumi
    cmd(1'b0, 16'h0003, '0);
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 16'h0001; cfg_data_i = 64'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 64'(cfg_ready_o), 64'd0);
      chk("bp_resp_v", 64'(resp_v_o), 64'd1);
      chk("bp_resp_data", resp_data_o, 64'hF);
      @(negedge clk_i);
    end
    resp_yumi_i = 1'b1;
    @(negedge clk_i);
    resp_yumi_i = 1'b0;
    chk("bp_ready_after_yumi", 64'(cfg_ready_o), 64'd1);
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    chk("bp_next_accepted", 64'(resp_v_o), 64'd1); chk("bp_reset_written", 64'(reset_o), 64'd1);
    ack();

    // Asynchronous reset while a response is pending
    cmd(1'b1, 16'h0002, 64'd0); chk("frz_cleared", 64'(freeze_o), 64'd0);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_resp_v", 64'(resp_v_o), 64'd0); chk("arst_freeze", 64'(freeze_o), 64'd1);
    chk("arst_ready", 64'(cfg_ready_o), 64'd1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("no_stale_resp", 64'(resp_v_o), 64'd0);

    // Randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 4000; c++) begin
      cfg_v_i     = 1'($urandom_range(1, 0));
      cfg_w_i     = 1'($urandom_range(1, 0));
      cfg_addr_i  = rand_addr();
      cfg_data_i  = {$urandom, $urandom};
      resp_yumi_i = ($urandom_range(2, 0) != 0);
      if ($urandom_range(399, 0) == 0) begin
        #2 reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
      end else begin
        @(negedge clk_i);
      end
    end

    cfg_v_i = 1'b0; resp_yumi_i = 1'b0;
    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
